// File: rtl/sss_pkg.sv
// Shared definitions for the SSS search sequencer.
//   SSS_LEN  : width of one SSS word (received and local hypotheses)
//   NUM_NID1 : default number of N_ID1 hypotheses
//   METRIC_W : width of a correlator result
//   CNT_W    : width of the correlator-latency wait counter (latency 1..15)
//   state_t  : sequencer states
package sss_pkg;
  localparam int SSS_LEN  = 62;
  localparam int NUM_NID1 = 168;
  localparam int METRIC_W = 32;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT,
    CMP,
    DONE
  } state_t;
endpackage

// File: rtl/sss_search_ctrl_if.sv
// Bundle of the sequencer's control, ROM and correlator signals.
//   control   : start, abort, rx_sss_in, threshold -> busy, done, best_idx,
//               best_metric, found
//   ROM       : rom_en, rom_addr -> rom_data (one cycle later)
//   correlator: received_sss, local_sss -> correlation_result
// The slave modport is the sequencer's view; master is everything around it
// (cell-search top level, ROM and correlator).
interface sss_search_ctrl_if
  import sss_pkg::*;
  #(parameter int NUM_HYP = NUM_NID1,
    parameter int IDX_W   = $clog2(NUM_HYP))
  ();
  logic                start;
  logic                abort;
  logic [SSS_LEN-1:0]  rx_sss_in;
  logic [METRIC_W-1:0] threshold;
  logic                rom_en;
  logic [IDX_W-1:0]    rom_addr;
  logic [SSS_LEN-1:0]  rom_data;
  logic [SSS_LEN-1:0]  received_sss;
  logic [SSS_LEN-1:0]  local_sss;
  logic [METRIC_W-1:0] correlation_result;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    best_idx;
  logic [METRIC_W-1:0] best_metric;
  logic                found;

  modport slave (
    input  start, abort, rx_sss_in, threshold, rom_data, correlation_result,
    output rom_en, rom_addr, received_sss, local_sss,
           busy, done, best_idx, best_metric, found
  );

  modport master (
    output start, abort, rx_sss_in, threshold, rom_data, correlation_result,
    input  rom_en, rom_addr, received_sss, local_sss,
           busy, done, best_idx, best_metric, found
  );
endinterface

// File: rtl/sss_peak_tracker.sv
// Running peak tracker for the SSS search.
//   clk, reset : clock, synchronous active-low reset
//   clear      : zero the running peak (start of a search)
//   update     : a correlator sample is presented this cycle
//   first      : the sample belongs to hypothesis 0 and is always taken
//   metric/idx : sample value and its hypothesis index
//   run_best/run_idx : current peak value and index
module sss_peak_tracker
  import sss_pkg::*;
  #(parameter int IDX_W = 8)
  (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                update,
    input  logic                first,
    input  logic [METRIC_W-1:0] metric,
    input  logic [IDX_W-1:0]    idx,
    output logic [METRIC_W-1:0] run_best,
    output logic [IDX_W-1:0]    run_idx
  );

  // Strictly-greater compare keeps the lowest index on ties; the first
  // hypothesis always loads so an all-zero search still reports index 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_best <= '0;
      run_idx  <= '0;
    end else if (clear) begin
      run_best <= '0;
      run_idx  <= '0;
    end else if (update && (first || (metric > run_best))) begin
      run_best <= metric;
      run_idx  <= idx;
    end
  end
endmodule

// File: rtl/sss_search_ctrl.sv
// SSS search sequencer. Latches a received SSS word on start, walks the
// NUM_HYP hypotheses from the sequence ROM (FETCH, LATCH, CORR_LAT x WAIT,
// CMP per hypothesis), tracks the peak correlation and publishes the best
// index, peak metric and threshold-detect flag with a one-cycle done pulse.
//   clk, reset : clock, synchronous active-low reset
//   bus        : control, ROM and correlator signals (slave view)
module sss_search_ctrl
  import sss_pkg::*;
  #(parameter int NUM_HYP  = NUM_NID1,
    parameter int CORR_LAT = 1,
    parameter int IDX_W    = $clog2(NUM_HYP))
  (
    input  logic           clk,
    input  logic           reset,
    sss_search_ctrl_if.slave bus
  );

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    hyp;
  logic [CNT_W-1:0]    wait_cnt;
  logic [METRIC_W-1:0] thr_lat;
  logic [METRIC_W-1:0] run_best;
  logic [IDX_W-1:0]    run_idx;
  logic                accept;
  logic                cmp_go;
  logic                last_hyp;

  assign last_hyp     = (hyp == IDX_W'(NUM_HYP - 1));
  assign bus.rom_en   = (state == FETCH);
  assign bus.rom_addr = hyp;
  assign bus.busy     = (state != IDLE);

  // Next-state logic; abort overrides every transition, and in IDLE it
  // also suppresses a coincident start.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cmp_go    = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = FETCH;
      FETCH: state_nxt = LATCH;
      LATCH: state_nxt = WAIT;
      WAIT:  if (wait_cnt == CNT_W'(1)) state_nxt = CMP;
      CMP:   state_nxt = last_hyp ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
    accept = (state == IDLE) && bus.start && !bus.abort;
    cmp_go = (state == CMP) && !bus.abort;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers. Every load is gated by abort so an aborted search
  // leaves the correlator inputs and published results untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hyp              <= '0;
      wait_cnt         <= '0;
      thr_lat          <= '0;
      bus.received_sss <= '0;
      bus.local_sss    <= '0;
      bus.done         <= 1'b0;
      bus.best_idx     <= '0;
      bus.best_metric  <= '0;
      bus.found        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        bus.received_sss <= bus.rx_sss_in;
        thr_lat          <= bus.threshold;
        hyp              <= '0;
      end
      if ((state == LATCH) && !bus.abort) begin
        bus.local_sss <= bus.rom_data;
        wait_cnt      <= CNT_W'(CORR_LAT);
      end
      if ((state == WAIT) && !bus.abort) wait_cnt <= wait_cnt - CNT_W'(1);
      if (cmp_go && !last_hyp) hyp <= hyp + IDX_W'(1);
      if ((state == DONE) && !bus.abort) begin
        bus.best_idx    <= run_idx;
        bus.best_metric <= run_best;
        bus.found       <= (run_best >= thr_lat);
        bus.done        <= 1'b1;
      end
    end
  end

  sss_peak_tracker #(.IDX_W(IDX_W)) u_peak (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .update   (cmp_go),
    .first    (hyp == '0),
    .metric   (bus.correlation_result),
    .idx      (hyp),
    .run_best (run_best),
    .run_idx  (run_idx)
  );
endmodule

// File: tb/tb_sss_search_ctrl.sv
// Bench for sss_search_ctrl. Two instances: a small one (4 hypotheses,
// correlator latency 1) for the functional scenarios and random searches,
// and a full-size one (168 hypotheses, latency 3) for the latency sweep.
// The bench models the sequence ROM and a pipelined correlator whose result
// is the metric assigned to whichever ROM word is presented as local_sss.
module tb_sss_search_ctrl;
  import sss_pkg::*;

  localparam int S_N = 4;
  localparam int S_L = 1;
  localparam int L_N = 168;
  localparam int L_L = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [SSS_LEN-1:0]  s_rom    [0:255];
  logic [SSS_LEN-1:0]  l_rom    [0:255];
  logic [METRIC_W-1:0] s_metric [0:255];
  logic [METRIC_W-1:0] l_metric [0:255];
  logic [METRIC_W-1:0] l_p1, l_p2;
  int s_addr_q[$];
  int l_addr_q[$];

  sss_search_ctrl_if #(.NUM_HYP(S_N)) s_bus ();
  sss_search_ctrl_if #(.NUM_HYP(L_N)) l_bus ();

  sss_search_ctrl #(.NUM_HYP(S_N), .CORR_LAT(S_L)) u_small (
    .clk(clk), .reset(reset), .bus(s_bus)
  );
  sss_search_ctrl #(.NUM_HYP(L_N), .CORR_LAT(L_L)) u_large (
    .clk(clk), .reset(reset), .bus(l_bus)
  );

  // Correlator behaviour: a ROM word carries its index in the low byte.
  function automatic logic [METRIC_W-1:0] corrModel(input bit big, input logic [SSS_LEN-1:0] w);
    int idx;
    idx = int'(w[7:0]);
    if (big) begin
      if (idx < L_N && w == l_rom[idx]) return l_metric[idx];
    end else begin
      if (idx < S_N && w == s_rom[idx]) return s_metric[idx];
    end
    return '0;
  endfunction

  // ROM with one-cycle read latency and correlator pipelines of depth CORR_LAT.
  always @(posedge clk) begin
    if (s_bus.rom_en) s_bus.rom_data <= s_rom[s_bus.rom_addr];
    s_bus.correlation_result <= corrModel(1'b0, s_bus.local_sss);
    if (l_bus.rom_en) l_bus.rom_data <= l_rom[l_bus.rom_addr];
    l_p1 <= corrModel(1'b1, l_bus.local_sss);
    l_p2 <= l_p1;
    l_bus.correlation_result <= l_p2;
  end

  // Record every ROM address issued while the strobe is high.
  always @(negedge clk) begin
    if (s_bus.rom_en) s_addr_q.push_back(int'(s_bus.rom_addr));
    if (l_bus.rom_en) l_addr_q.push_back(int'(l_bus.rom_addr));
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: argmax with lowest index on ties, found if peak >= threshold.
  task automatic refModel(input bit big, input logic [31:0] thr,
                          output int idx, output logic [31:0] best, output bit fnd);
    int n;
    logic [31:0] m;
    n = big ? L_N : S_N;
    best = big ? l_metric[0] : s_metric[0];
    idx = 0;
    for (int i = 1; i < n; i++) begin
      m = big ? l_metric[i] : s_metric[i];
      if (m > best) begin
        best = m;
        idx = i;
      end
    end
    fnd = (best >= thr);
  endtask

  task automatic setSmall(input logic [31:0] a, b, c, d);
    s_metric[0] = a; s_metric[1] = b; s_metric[2] = c; s_metric[3] = d;
  endtask

  task automatic checkAllZero(input string pre);
    checkOutput({pre, "_rom_en"}, 64'(s_bus.rom_en), 0);
    checkOutput({pre, "_rom_addr"}, 64'(s_bus.rom_addr), 0);
    checkOutput({pre, "_received_sss"}, 64'(s_bus.received_sss), 0);
    checkOutput({pre, "_local_sss"}, 64'(s_bus.local_sss), 0);
    checkOutput({pre, "_busy"}, 64'(s_bus.busy), 0);
    checkOutput({pre, "_done"}, 64'(s_bus.done), 0);
    checkOutput({pre, "_best_idx"}, 64'(s_bus.best_idx), 0);
    checkOutput({pre, "_best_metric"}, 64'(s_bus.best_metric), 0);
    checkOutput({pre, "_found"}, 64'(s_bus.found), 0);
  endtask

  // Run one full search on the chosen instance and check everything it
  // publishes; optionally pulse start mid-search with different inputs.
  task automatic applyStimulus(input bit big, input logic [31:0] thr, input bit pulse_mid);
    int n, lat_exp, bad, e_idx;
    logic [63:0] r;
    logic [SSS_LEN-1:0] rx;
    logic [31:0] e_best;
    bit e_fnd, obs_done;
    int q[$];
    r = {$urandom, $urandom};
    rx = r[SSS_LEN-1:0];
    lat_exp = big ? L_N * (L_L + 3) + 1 : S_N * (S_L + 3) + 1;
    refModel(big, thr, e_idx, e_best, e_fnd);
    if (big) begin
      l_addr_q.delete();
      l_bus.start = 1'b1; l_bus.rx_sss_in = rx; l_bus.threshold = thr;
    end else begin
      s_addr_q.delete();
      s_bus.start = 1'b1; s_bus.rx_sss_in = rx; s_bus.threshold = thr;
    end
    @(posedge clk); #1;
    s_bus.start = 1'b0; l_bus.start = 1'b0;
    checkOutput("busy_after_start", 64'(big ? l_bus.busy : s_bus.busy), 1);
    n = 0;
    obs_done = 1'b0;
    while (n < lat_exp + 20 && !obs_done) begin
      @(posedge clk); #1;
      n++;
      if (pulse_mid && n == 5) begin
        s_bus.start = 1'b1; s_bus.rx_sss_in = ~rx; s_bus.threshold = '0;
      end else begin
        s_bus.start = 1'b0;
      end
      obs_done = big ? l_bus.done : s_bus.done;
    end
    s_bus.start = 1'b0;
    checkOutput("done_latency", 64'(n), 64'(lat_exp));
    checkOutput("busy_at_done", 64'(big ? l_bus.busy : s_bus.busy), 0);
    checkOutput("best_idx", big ? 64'(l_bus.best_idx) : 64'(s_bus.best_idx), 64'(e_idx));
    checkOutput("best_metric", big ? 64'(l_bus.best_metric) : 64'(s_bus.best_metric), 64'(e_best));
    checkOutput("found", 64'(big ? l_bus.found : s_bus.found), 64'(e_fnd));
    checkOutput("received_sss", big ? 64'(l_bus.received_sss) : 64'(s_bus.received_sss), 64'(rx));
    if (big) q = l_addr_q;
    else     q = s_addr_q;
    bad = 0;
    if (q.size() != (big ? L_N : S_N)) bad++;
    for (int i = 0; i < q.size(); i++) if (q[i] != i) bad++;
    checkOutput("rom_addr_seq", 64'(bad), 0);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", 64'(big ? l_bus.done : s_bus.done), 0);
    checkOutput("best_idx_hold", big ? 64'(l_bus.best_idx) : 64'(s_bus.best_idx), 64'(e_idx));
  endtask

  initial begin
    int n;
    logic [63:0] r;
    logic [SSS_LEN-1:0] rx_hold;
    logic [31:0] thr;
    for (int i = 0; i < 256; i++) begin
      r = {$urandom, $urandom};
      s_rom[i] = {1'b1, r[52:0], 8'(i)};
      r = {$urandom, $urandom};
      l_rom[i] = {1'b1, r[52:0], 8'(i)};
      s_metric[i] = '0;
      l_metric[i] = '0;
    end
    s_bus.start = 1'b0; s_bus.abort = 1'b0; s_bus.rx_sss_in = '0; s_bus.threshold = '0;
    l_bus.start = 1'b0; l_bus.abort = 1'b0; l_bus.rx_sss_in = '0; l_bus.threshold = '0;

    $display("[TB] reset state");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    checkOutput("reset_large_busy", 64'(l_bus.busy), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic, tie, all-zero searches");
    setSmall(10, 50, 30, 20); applyStimulus(1'b0, 40, 1'b0);
    setSmall(7, 9, 9, 3);     applyStimulus(1'b0, 100, 1'b0);
    setSmall(0, 0, 0, 0);     applyStimulus(1'b0, 0, 1'b0);

    $display("[TB] start with abort in IDLE");
    s_bus.start = 1'b1; s_bus.abort = 1'b1;
    @(posedge clk); #1;
    s_bus.start = 1'b0; s_bus.abort = 1'b0;
    checkOutput("start_abort_idle_busy", 64'(s_bus.busy), 0);

    $display("[TB] abort during hypothesis 2");
    setSmall(5, 60, 2, 1); applyStimulus(1'b0, 40, 1'b0);
    setSmall(90, 1, 1, 1);
    s_bus.start = 1'b1; s_bus.rx_sss_in = ~s_bus.rx_sss_in; s_bus.threshold = '0;
    @(posedge clk); #1;
    s_bus.start = 1'b0;
    n = 0;
    while (n < 50 && !(s_bus.rom_en && s_bus.rom_addr == 2'd2)) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("abort_reached_hyp2", 64'(n < 50), 1);
    rx_hold = s_bus.received_sss;
    s_bus.abort = 1'b1;
    @(posedge clk); #1;
    s_bus.abort = 1'b0;
    checkOutput("abort_busy", 64'(s_bus.busy), 0);
    checkOutput("abort_done", 64'(s_bus.done), 0);
    checkOutput("abort_best_idx", 64'(s_bus.best_idx), 1);
    checkOutput("abort_best_metric", 64'(s_bus.best_metric), 60);
    checkOutput("abort_received_hold", 64'(s_bus.received_sss), 64'(rx_hold));
    checkOutput("abort_local_hold", 64'(s_bus.local_sss), 64'(s_rom[1]));
    applyStimulus(1'b0, 50, 1'b0);

    $display("[TB] start while busy");
    setSmall(3, 4, 80, 2); applyStimulus(1'b0, 81, 1'b1);

    $display("[TB] reset mid-search");
    s_bus.start = 1'b1;
    @(posedge clk); #1;
    s_bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkAllZero("midreset");
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] random searches");
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < S_N; i++)
        s_metric[i] = (k % 2 == 1) ? 32'($urandom_range(0, 7)) : $urandom;
      thr = s_metric[$urandom_range(0, S_N - 1)] + 32'($urandom_range(0, 1));
      if (k % 3 == 0) thr = '0;
      applyStimulus(1'b0, thr, 1'b0);
    end

    $display("[TB] latency sweep, 168 hypotheses, latency 3");
    for (int i = 0; i < L_N; i++) l_metric[i] = 32'($urandom_range(0, 1000));
    l_metric[L_N - 1] = 5000;
    applyStimulus(1'b1, 4999, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sss_search_ctrl.md
Name: sss_search_ctrl

Overview:
- Sequencer for the SSS correlator. On each start it latches one received 62-bit SSS word.
- It then steps through NUM_HYP local SSS hypotheses read from an external sequence ROM, presents each hypothesis to the correlator, and waits the correlator latency.
- It tracks the peak correlation_result and publishes the best hypothesis index, the peak metric and a threshold-detect flag.
- Sits between the cell-search top level and the correlator and ROM instances.

Parameters:
- SSS_LEN, 62, SSS word width in bits.
- NUM_HYP, 168, number of local hypotheses (N_ID1 candidates), range 2..256.
- METRIC_W, 32, correlator result width.
- CORR_LAT, 1, correlator input-to-result latency in cycles, range 1..15.
- IDX_W, $clog2(NUM_HYP), hypothesis index width.

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, synchronous, active-low.
- start, in, 1, request a search; accepted only when busy=0.
- abort, in, 1, cancel a running search.
- rx_sss_in, in, SSS_LEN, received SSS word; sampled on the start-accept cycle.
- threshold, in, METRIC_W, detect threshold; sampled on the start-accept cycle.
- rom_en, out, 1, ROM read strobe.
- rom_addr, out, IDX_W, ROM hypothesis address.
- rom_data, in, SSS_LEN, ROM read data; valid one cycle after rom_en.
- received_sss, out, SSS_LEN, to correlator.
- local_sss, out, SSS_LEN, to correlator.
- correlation_result, in, METRIC_W, from correlator; unsigned.
- busy, out, 1, high from the cycle after start-accept through the DONE cycle.
- done, out, 1, one-cycle pulse when results update.
- best_idx, out, IDX_W, index of the peak hypothesis.
- best_metric, out, METRIC_W, peak metric.
- found, out, 1, best_metric >= latched threshold.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: rom_en, rom_addr, received_sss, local_sss, busy, done, best_idx, best_metric, found.
  - Internal run_best, run_idx, hyp counter and wait counter are cleared.
  - A reset mid-search discards all progress.
- States: IDLE, FETCH, LATCH, WAIT, CMP, DONE.
- IDLE:
  - start=1 latches rx_sss_in into received_sss and latches threshold.
  - Clears hyp=0, run_best=0, run_idx=0, then goes to FETCH.
  - start while busy=1 is ignored.
- FETCH: rom_en=1, rom_addr=hyp for exactly one cycle, then LATCH. rom_en is 0 in every other state.
- LATCH: local_sss <= rom_data, wait counter <= CORR_LAT, then WAIT.
- WAIT: decrement the counter; go to CMP on the cycle the counter reaches 1. WAIT therefore lasts CORR_LAT cycles.
- CMP:
  - Sample correlation_result. Update run_best/run_idx only if the sample is strictly greater than run_best, so ties keep the lower index.
  - hyp=0 always loads run_best/run_idx (a first result of 0 still records idx 0).
  - If hyp==NUM_HYP-1, go to DONE; else hyp+1 and go to FETCH.
- DONE:
  - best_idx <= run_idx, best_metric <= run_best, found <= (run_best >= threshold_latched).
  - done=1 for this cycle only, then IDLE.
- busy deasserts in the cycle after DONE.
- Cycles per hypothesis: CORR_LAT+3.
- Latency from start-accept edge to the done pulse: NUM_HYP*(CORR_LAT+3)+1 cycles.
- Published results (best_idx, best_metric, found) change only in DONE and hold until the next DONE or reset.
- abort=1 in any non-IDLE state goes to IDLE on the next edge:
  - no done pulse; published results unchanged.
  - received_sss and local_sss hold their values.
  - abort has priority over every state transition, including DONE.
- start and abort together in IDLE: abort wins and start is ignored.
- local_sss and received_sss are held stable from LATCH through CMP of each hypothesis.
- The hyp counter never wraps; the last address issued is NUM_HYP-1.

Decomposition:
- Shared package sss_pkg holds:
  - SSS_LEN=62, NUM_NID1=168, METRIC_W=32.
  - The state enum: IDLE, FETCH, LATCH, WAIT, CMP, DONE.
- One sub-module, sss_peak_tracker, holds run_best/run_idx with clear, update strobe and strict-greater compare.
- The FSM, counters and output registers stay in sss_search_ctrl.

Test Plan:
- Basic peak search:
  - Setup: NUM_HYP=4, CORR_LAT=1, bench correlator model returns metrics {10,50,30,20}, threshold=40.
  - Required: done exactly 17 cycles after start-accept; best_idx=1, best_metric=50, found=1; rom_addr sequence 0,1,2,3.
- Tie and below threshold:
  - Setup: metrics {7,9,9,3}, threshold=100.
  - Required: best_idx=1, best_metric=9, found=0.
- All zero:
  - Setup: metrics {0,0,0,0}.
  - Required: best_idx=0, best_metric=0, found=(threshold==0); check with threshold=0 giving found=1.
- Abort:
  - Setup: complete one search (best_idx=1), start a second, assert abort during hypothesis 2.
  - Required: busy=0 next cycle; no done; best_idx remains 1; a new start is accepted the following cycle.
- Start while busy and reset mid-search:
  - Stimulus: pulse start mid-search.
  - Required: ignored; the original search completes with the correct latency.
  - Stimulus: reset=0 mid-search for 1 cycle.
  - Required: all outputs 0, state IDLE.
- Latency sweep:
  - Setup: CORR_LAT=3, NUM_HYP=168, single peak at idx 167.
  - Required: done after 168*6+1 = 1009 cycles; best_idx=167.
